abus_master_sequencer: RTL and testbench
========================================

ABUS_MASTER_SEQUENCER -- requirements
Module: abus_master_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, bus data width.
REQ-003 The block SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, maximum cycles a bus strobe may stay asserted (>=1).
REQ-005 The block SHALL have port abus_clk  in  1  single clock, all logic rising-edge.
REQ-006 The block SHALL have port abus_rst  in  1  asynchronous, active-high reset.
REQ-007 The block SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-008 The block SHALL have ports cmd_op in 2 (00 read, 01 write, 10 read-modify-write, 11 reserved), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wmask in DATA_WIDTH (bit-enable).
REQ-009 The block SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-010 The block SHALL have ports rsp_rdata out DATA_WIDTH, rsp_err out 1, rsp_timeout out 1.
REQ-011 The block SHALL have bus ports bus_write out 1, bus_read out 1, bus_address out ADDR_WIDTH, bus_wdata out DATA_WIDTH.
REQ-012 The block SHALL have bus ports bus_done in 1, bus_new_rdata in 1, bus_err in 1, bus_rdata in DATA_WIDTH.

Function
REQ-013 Command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL equal FIFO-not-full, with no same-cycle bypass when full.
REQ-014 FSM states SHALL be IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
REQ-015 In IDLE with FIFO non-empty, the FSM SHALL pop one entry and enter RD/WR/RMW_RD per op; bus strobe, address and wdata SHALL be registered and asserted on the following cycle.
REQ-016 Op 11 SHALL enter RESP directly with rsp_err=1, rsp_timeout=0, rsp_rdata=0, and no bus access.
REQ-017 RD SHALL hold bus_read=1 until bus_new_rdata or bus_err; WR SHALL hold bus_write=1 until bus_done or bus_err; strobe SHALL drop the cycle after completion.
REQ-018 bus_err SHALL take priority over bus_done/bus_new_rdata when sampled in the same cycle.
REQ-019 RD SHALL capture bus_rdata on the completion cycle into rsp_rdata; WR SHALL return rsp_rdata=0.
REQ-020 RMW_RD SHALL read as RD; on success RMW_WR SHALL write (rdata & ~wmask) | (wdata & wmask) to the same address; rsp_rdata SHALL be the original read value.
REQ-021 RMW SHALL abort after a failed or timed-out read phase, with no write phase issued.
REQ-022 A cycle counter SHALL reset on each strobe assertion; if TIMEOUT strobe cycles elapse without completion, strobe SHALL drop and the response SHALL carry rsp_err=1, rsp_timeout=1.
REQ-023 Completion and timeout in the same cycle SHALL be treated as completion.
REQ-024 RESP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then return to IDLE; a new command SHALL not start while a response is pending.
REQ-025 bus_read and bus_write SHALL never be asserted simultaneously.

Reset
REQ-026 While abus_rst=1, the block SHALL force state IDLE, FIFO empty, and all outputs 0 (cmd_ready=0, bus strobes low) asynchronously.
REQ-027 Reset mid-transaction SHALL drop any strobe immediately; in-flight and queued commands SHALL be discarded without a response.
REQ-028 cmd_ready SHALL assert on the first clock edge after abus_rst deasserts.

Structure
REQ-029 Package abus_pkg SHALL hold the op enum (OP_READ, OP_WRITE, OP_RMW, OP_RSVD) and the FSM state enum.
REQ-030 The command FIFO SHALL be a sub-module abus_cmd_fifo (parametrised width and depth, full/empty flags, pointer wrap).

Verification
REQ-031 Write 0x1234 @0x0010, bus_done after 2 cycles -> bus_write high 3 cycles, rsp_valid, err=0, rdata=0.
REQ-032 Read @0x0020, bus_new_rdata with 0xBEEF -> rsp_rdata=0xBEEF, err=0; back-to-back 4 reads keep FIFO order.
REQ-033 RMW @0x0030, mask 0x00FF, wdata 0x00AA, bus read 0x1234 -> bus_wdata 0x12AA, rsp_rdata=0x1234.
REQ-034 TIMEOUT=8, bus never responds -> strobe drops after 8 cycles, rsp_err=1, rsp_timeout=1; RMW issues no write.
REQ-035 Push 5 commands with rsp_ready=0 and CMD_DEPTH=4 -> cmd_ready low once 4 entries queued after first pop; bus_done with bus_err same cycle -> rsp_err=1.
REQ-036 Assert abus_rst during bus_write -> bus_write low without a clock edge, no response, cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/abus_pkg.sv
// Shared types for the ABUS master sequencer: command opcodes and sequencer FSM states.
package abus_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RMW   = 2'b10,
        OP_RSVD  = 2'b11
    } abus_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } abus_state_t;

endpackage

// File: rtl/abus_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), extra pointer MSB tells full from empty on wrap.
module abus_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/abus_master_sequencer.sv
// ABUS master: queues read/write/RMW commands and runs them one at a time on the bus,
// with a per-strobe timeout. Handshake: a transfer happens on any rising edge where valid && ready.
module abus_master_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  abus_clk,
    input  logic                  abus_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  bus_write,
    output logic                  bus_read,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_done,
    input  logic                  bus_new_rdata,
    input  logic                  bus_err,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [2:0]            dbg_state
);
    import abus_pkg::*;

    localparam int FW = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    abus_state_t           state;
    logic                  rdy_en;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wmask_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [FW-1:0]         fifo_dout;
    abus_op_t              head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [DATA_WIDTH-1:0] head_wmask;

    // rdy_en keeps cmd_ready low during reset and lets it rise on the first edge after release.
    assign cmd_ready = rdy_en && !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign dbg_state = state;

    assign head_op    = abus_op_t'(fifo_dout[FW-1 -: 2]);
    assign head_addr  = fifo_dout[2*DATA_WIDTH +: ADDR_WIDTH];
    assign head_wdata = fifo_dout[DATA_WIDTH +: DATA_WIDTH];
    assign head_wmask = fifo_dout[0 +: DATA_WIDTH];

    abus_cmd_fifo #(.WIDTH(FW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (abus_clk),
        .rst       (abus_rst),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_op, cmd_addr, cmd_wdata, cmd_wmask}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge abus_clk or posedge abus_rst) begin
        if (abus_rst) begin
            state       <= IDLE;
            rdy_en      <= 1'b0;
            cnt         <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= '0;
            bus_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cnt         <= '0;
                        bus_address <= head_addr;
                        wdata_q     <= head_wdata;
                        wmask_q     <= head_wmask;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        case (head_op)
                            OP_READ:  begin bus_read <= 1'b1; state <= RD; end
                            OP_WRITE: begin bus_write <= 1'b1; bus_wdata <= head_wdata; state <= WR; end
                            OP_RMW:   begin bus_read <= 1'b1; state <= RMW_RD; end
                            default:  begin rsp_valid <= 1'b1; rsp_err <= 1'b1; state <= RESP; end
                        endcase
                    end
                end
                RD, RMW_RD: begin
                    // Error beats data; data beats a simultaneous timeout.
                    if (bus_err) begin
                        bus_read  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else if (bus_new_rdata) begin
                        bus_read  <= 1'b0;
                        rsp_rdata <= bus_rdata;
                        if (state == RMW_RD) begin
                            bus_write <= 1'b1;
                            bus_wdata <= (bus_rdata & ~wmask_q) | (wdata_q & wmask_q);
                            cnt       <= '0;
                            state     <= RMW_WR;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus_read    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WR, RMW_WR: begin
                    if (bus_err || bus_done) begin
                        bus_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= bus_err;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus_write   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abus_master_sequencer.sv
// Directed bench for abus_master_sequencer (TIMEOUT=8, CMD_DEPTH=4, 16-bit address/data).
module tb_abus_master_sequencer;

    logic        abus_clk = 1'b0;
    logic        abus_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        bus_write;
    logic        bus_read;
    logic [15:0] bus_address;
    logic [15:0] bus_wdata;
    logic        bus_done;
    logic        bus_new_rdata;
    logic        bus_err;
    logic [15:0] bus_rdata;
    logic [2:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 abus_clk = ~abus_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    abus_master_sequencer #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .CMD_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .abus_clk      (abus_clk),
        .abus_rst      (abus_rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wmask     (cmd_wmask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_address   (bus_address),
        .bus_wdata     (bus_wdata),
        .bus_done      (bus_done),
        .bus_new_rdata (bus_new_rdata),
        .bus_err       (bus_err),
        .bus_rdata     (bus_rdata),
        .dbg_state     (dbg_state)
    );

    // Strobes must be mutually exclusive on every cycle.
    always @(negedge abus_clk) begin
        if (!abus_rst) begin
            vectors++;
            if (bus_read && bus_write) begin
                miscompares++;
                $display("FAIL strobe_exclusive: bus_read=%0b bus_write=%0b required not both", bus_read, bus_write);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_cmd(input logic [1:0] op, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] wmask);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wmask = wmask;
        while (!cmd_ready && n < 100) begin
            @(negedge abus_clk);
            n++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL push_accept: cmd_ready=%0b required 1 within 100 cycles", cmd_ready);
        end
        @(negedge abus_clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for the selected strobe, holds off `delay` cycles, then drives one completion cycle.
    task automatic serve_phase(input bit is_read, input int delay, input logic [15:0] rdata,
                               input bit done_v, input bit err_v,
                               output logic [15:0] addr_seen, output logic [15:0] wdata_seen);
        int n = 0;
        while (!(is_read ? bus_read : bus_write) && n < 100) begin
            @(negedge abus_clk);
            n++;
        end
        vectors++;
        if (!(is_read ? bus_read : bus_write)) begin
            miscompares++;
            $display("FAIL strobe_start: %s strobe=0 required 1 within 100 cycles", is_read ? "read" : "write");
        end
        addr_seen  = bus_address;
        wdata_seen = bus_wdata;
        repeat (delay) @(negedge abus_clk);
        if (is_read) begin
            bus_new_rdata = done_v;
            bus_rdata     = rdata;
        end else begin
            bus_done = done_v;
        end
        bus_err = err_v;
        @(negedge abus_clk);
        bus_new_rdata = 1'b0;
        bus_done      = 1'b0;
        bus_err       = 1'b0;
        bus_rdata     = 16'h0000;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge abus_clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        vectors++;
        if ({cmd_ready, rsp_valid, bus_read, bus_write, rsp_err, rsp_timeout} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {cmd_ready, rsp_valid, bus_read, bus_write, rsp_err, rsp_timeout});
        end
        repeat (2) @(negedge abus_clk);
        vectors++;
        if (cmd_ready !== 1'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_hold: cmd_ready=%0b state=%0d required 0/0", cmd_ready, dbg_state);
        end
        abus_rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: cmd_ready=%0b required 0", cmd_ready);
        end
        @(negedge abus_clk);
        vectors++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL ready_after_edge: cmd_ready=%0b state=%0d required 1/0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_write();
        int hi = 0;
        int n  = 0;
        rsp_ready = 1'b0;
        push_cmd(2'b01, 16'h0010, 16'h1234, 16'hFFFF);
        while (!bus_write && n < 50) begin
            @(negedge abus_clk);
            n++;
        end
        if (bus_write) hi = 1;
        vectors++;
        if (bus_address !== 16'h0010 || bus_wdata !== 16'h1234 || bus_read !== 1'b0) begin
            miscompares++;
            $display("FAIL write_bus: addr=%h wdata=%h rd=%0b required 0010/1234/0",
                     bus_address, bus_wdata, bus_read);
        end
        @(negedge abus_clk);
        if (bus_write) hi++;
        @(negedge abus_clk);
        if (bus_write) hi++;
        bus_done = 1'b1;
        @(negedge abus_clk);
        bus_done = 1'b0;
        vectors++;
        if (hi !== 3 || bus_write !== 1'b0) begin
            miscompares++;
            $display("FAIL write_strobe_len: high=%0d after=%0b required 3/0", hi, bus_write);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL write_rsp: v/e/t=%b rdata=%h required 100/0000",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        ack_rsp();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL write_rsp_ack: rsp_valid=%0b required 0", rsp_valid);
        end
    endtask

    task automatic test_read();
        logic [15:0] a, w;
        rsp_ready = 1'b0;
        push_cmd(2'b00, 16'h0020, 16'h0000, 16'h0000);
        serve_phase(1'b1, 1, 16'hBEEF, 1'b1, 1'b0, a, w);
        vectors++;
        if (a !== 16'h0020 || bus_read !== 1'b0) begin
            miscompares++;
            $display("FAIL read_bus: addr=%h rd_after=%0b required 0020/0", a, bus_read);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read_rsp: v/e/t=%b rdata=%h required 100/beef",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, w, exp_d;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'b00, 16'h0040 + 16'(i), 16'h0000, 16'h0000);
            exp_q.push_back(16'hA000 + 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            serve_phase(1'b1, 0, 16'hA000 + 16'(i), 1'b1, 1'b0, a, w);
            vectors++;
            if (a !== 16'h0040 + 16'(i) || rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
                miscompares++;
                $display("FAIL b2b_read_%0d: addr=%h valid=%0b rdata=%h required %h/1/%h",
                         i, a, rsp_valid, rsp_rdata, 16'h0040 + 16'(i), exp_d);
            end
        end
        @(negedge abus_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_rmw();
        logic [15:0] a, w;
        rsp_ready = 1'b0;
        push_cmd(2'b10, 16'h0030, 16'h00AA, 16'h00FF);
        serve_phase(1'b1, 0, 16'h1234, 1'b1, 1'b0, a, w);
        vectors++;
        if (a !== 16'h0030) begin
            miscompares++;
            $display("FAIL rmw_read_addr: addr=%h required 0030", a);
        end
        serve_phase(1'b0, 1, 16'h0000, 1'b1, 1'b0, a, w);
        vectors++;
        if (a !== 16'h0030 || w !== 16'h12AA) begin
            miscompares++;
            $display("FAIL rmw_write: addr=%h wdata=%h required 0030/12aa", a, w);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL rmw_rsp: v/e/t=%b rdata=%h required 100/1234",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        ack_rsp();
    endtask

    task automatic test_rsvd();
        int  n = 0;
        bit  strobe_seen = 1'b0;
        rsp_ready = 1'b0;
        push_cmd(2'b11, 16'h0099, 16'hFFFF, 16'hFFFF);
        while (!rsp_valid && n < 50) begin
            if (bus_read || bus_write) strobe_seen = 1'b1;
            @(negedge abus_clk);
            n++;
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 16'h0000 || strobe_seen) begin
            miscompares++;
            $display("FAIL rsvd_rsp: v/e/t=%b rdata=%h strobe=%0b required 110/0000/0",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata, strobe_seen);
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int hi, n;
        bit wr_seen = 1'b0;
        logic [15:0] a, w;
        rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_cmd(k == 0 ? 2'b00 : 2'b10, 16'h0050 + 16'(k), 16'h00FF, 16'h00FF);
            n = 0;
            hi = 0;
            while (!bus_read && n < 50) begin
                @(negedge abus_clk);
                n++;
            end
            if (bus_read) hi = 1;
            n = 0;
            while (bus_read && n < 50) begin
                @(negedge abus_clk);
                if (bus_read) hi++;
                n++;
            end
            repeat (3) begin
                if (bus_write) wr_seen = 1'b1;
                @(negedge abus_clk);
            end
            vectors++;
            if (hi !== 8 || wr_seen) begin
                miscompares++;
                $display("FAIL timeout_len_%0d: high=%0d write_seen=%0b required 8/0", k, hi, wr_seen);
            end
            vectors++;
            if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin
                miscompares++;
                $display("FAIL timeout_rsp_%0d: v/e/t=%b required 111", k, {rsp_valid, rsp_err, rsp_timeout});
            end
            ack_rsp();
        end
        // Completion on the very cycle the timeout would fire counts as success.
        push_cmd(2'b00, 16'h0054, 16'h0000, 16'h0000);
        serve_phase(1'b1, 7, 16'h5A5A, 1'b1, 1'b0, a, w);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL timeout_edge: v/e/t=%b rdata=%h required 100/5a5a",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        ack_rsp();
    endtask

    task automatic test_fifo_full();
        logic [15:0] a, w;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(2'b01, 16'h0060 + 16'(i), 16'h0100 + 16'(i), 16'hFFFF);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_full_ready: cmd_ready=%0b required 0", cmd_ready);
        end
        serve_phase(1'b0, 0, 16'h0000, 1'b1, 1'b1, a, w);
        vectors++;
        if (a !== 16'h0060 || {rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
            miscompares++;
            $display("FAIL err_priority: addr=%h v/e/t=%b required 0060/110",
                     a, {rsp_valid, rsp_err, rsp_timeout});
        end
        repeat (2) @(negedge abus_clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || cmd_ready !== 1'b0 || bus_write !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_hold: valid=%0b err=%0b ready=%0b wr=%0b required 1/1/0/0",
                     rsp_valid, rsp_err, cmd_ready, bus_write);
        end
        rsp_ready = 1'b1;
        repeat (2) @(negedge abus_clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_pop: cmd_ready=%0b required 1", cmd_ready);
        end
        for (int i = 1; i < 5; i++) begin
            serve_phase(1'b0, 0, 16'h0000, 1'b1, 1'b0, a, w);
            vectors++;
            if (a !== 16'h0060 + 16'(i) || w !== 16'h0100 + 16'(i) || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL fifo_order_%0d: addr=%h wdata=%h valid=%0b err=%0b required %h/%h/1/0",
                         i, a, w, rsp_valid, rsp_err, 16'h0060 + 16'(i), 16'h0100 + 16'(i));
            end
        end
        @(negedge abus_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  n = 0;
        bit  activity = 1'b0;
        rsp_ready = 1'b1;
        push_cmd(2'b01, 16'h0070, 16'h7777, 16'hFFFF);
        push_cmd(2'b01, 16'h0071, 16'h7171, 16'hFFFF);
        while (!bus_write && n < 50) begin
            @(negedge abus_clk);
            n++;
        end
        #2;
        abus_rst = 1'b1;
        #1;
        vectors++;
        if (bus_write !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: wr=%0b ready=%0b valid=%0b required 0/0/0",
                     bus_write, cmd_ready, rsp_valid);
        end
        repeat (2) @(negedge abus_clk);
        abus_rst = 1'b0;
        @(negedge abus_clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: cmd_ready=%0b required 1", cmd_ready);
        end
        repeat (12) begin
            if (bus_write || bus_read || rsp_valid) activity = 1'b1;
            @(negedge abus_clk);
        end
        vectors++;
        if (activity) begin
            miscompares++;
            $display("FAIL reset_discard: bus or response activity=%0b required 0", activity);
        end
        rsp_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        abus_rst      = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = 2'b00;
        cmd_addr      = 16'h0000;
        cmd_wdata     = 16'h0000;
        cmd_wmask     = 16'h0000;
        rsp_ready     = 1'b0;
        bus_done      = 1'b0;
        bus_new_rdata = 1'b0;
        bus_err       = 1'b0;
        bus_rdata     = 16'h0000;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rmw();
        test_rsvd();
        test_timeout();
        test_fifo_full();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
